shared_reg_arbiter: RTL



---
 rtl/shared_reg_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/shared_reg_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : shared_reg_arbiter
// Description : Four-way round-robin arbiter that owns one shared WIDTH-bit
//               register. The granted requester writes its data into the
//               register on every cycle it keeps its request high. When the
//               owner drops its request, the grant passes to the next pending
//               requester on the same edge, with no idle cycle in between.
//               Optional macro SHARED_REG_ARB_TIMEOUT_EN forces the grant to
//               rotate after MAX_HOLD consecutive writes if another requester
//               is waiting.
// Revision    : 1.0 - initial release
// ============================================================================
module shared_reg_arbiter #(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] din0,
  input  logic [WIDTH-1:0] din1,
  input  logic [WIDTH-1:0] din2,
  input  logic [WIDTH-1:0] din3,
  output logic [3:0]       gnt,
  output logic [WIDTH-1:0] q,
  output logic             busy
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_ptr;
  logic [1:0]       w_ptr_nxt;
  logic [3:0]       r_gnt;
  logic [3:0]       w_gnt_nxt;
  logic             r_busy;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_nxt;
  logic [WIDTH-1:0] w_din_sel;
  logic [2:0]       w_pick_all;
  logic [2:0]       w_pick_oth;

`ifdef SHARED_REG_ARB_TIMEOUT_EN
  localparam logic [3:0] C_HOLD_LAST = 4'(MAX_HOLD - 1);
  logic [3:0] r_hcnt;
  logic [3:0] w_hcnt_nxt;
`endif

  // Round-robin search starting just after base and wrapping back to base.
  // Result is {found, index}.
  function automatic logic [2:0] rr_pick(input logic [1:0] base,
                                         input logic [3:0] mask);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 1; k <= 4; k++) begin
      idx = base + k[1:0];
      if (!res[2] && mask[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // In GRANT the pointer always names the current owner, so it selects the data.
  always_comb begin
    case (r_ptr)
      2'd0:    w_din_sel = din0;
      2'd1:    w_din_sel = din1;
      2'd2:    w_din_sel = din2;
      default: w_din_sel = din3;
    endcase
  end

  // Next-state, grant, pointer and data selection.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_ptr_nxt   = r_ptr;
    w_q_nxt     = r_q;
`ifdef SHARED_REG_ARB_TIMEOUT_EN
    w_hcnt_nxt  = r_hcnt;
`endif
    w_pick_all  = rr_pick(r_ptr, req);
    // Pending requesters other than the current owner.
    w_pick_oth  = rr_pick(r_ptr, req & ~r_gnt);

    case (r_state)
      ST_IDLE: begin
        if (w_pick_all[2]) begin
          w_gnt_nxt   = 4'b0001 << w_pick_all[1:0];
          w_ptr_nxt   = w_pick_all[1:0];
          w_state_nxt = ST_GRANT;
`ifdef SHARED_REG_ARB_TIMEOUT_EN
          w_hcnt_nxt  = 4'd0;
`endif
        end
      end
      ST_GRANT: begin
        if (req[r_ptr]) begin
          w_q_nxt = w_din_sel;
`ifdef SHARED_REG_ARB_TIMEOUT_EN
          // The write that reaches the hold limit still lands; the grant
          // moves on only if someone else is waiting.
          if (r_hcnt == C_HOLD_LAST && w_pick_oth[2]) begin
            w_gnt_nxt  = 4'b0001 << w_pick_oth[1:0];
            w_ptr_nxt  = w_pick_oth[1:0];
            w_hcnt_nxt = 4'd0;
          end else if (r_hcnt != C_HOLD_LAST) begin
            w_hcnt_nxt = r_hcnt + 4'd1;
          end
`endif
        end else if (w_pick_oth[2]) begin
          w_gnt_nxt  = 4'b0001 << w_pick_oth[1:0];
          w_ptr_nxt  = w_pick_oth[1:0];
`ifdef SHARED_REG_ARB_TIMEOUT_EN
          w_hcnt_nxt = 4'd0;
`endif
        end else begin
          w_gnt_nxt   = 4'b0000;
          w_state_nxt = ST_IDLE;
`ifdef SHARED_REG_ARB_TIMEOUT_EN
          w_hcnt_nxt  = 4'd0;
`endif
        end
      end
      default: begin
        w_gnt_nxt   = 4'b0000;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, grant, pointer and shared register; reset aborts any write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_gnt   <= 4'b0000;
      r_busy  <= 1'b0;
      r_ptr   <= 2'd3;
      r_q     <= '0;
`ifdef SHARED_REG_ARB_TIMEOUT_EN
      r_hcnt  <= 4'd0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_busy  <= |w_gnt_nxt;
      r_ptr   <= w_ptr_nxt;
      r_q     <= w_q_nxt;
`ifdef SHARED_REG_ARB_TIMEOUT_EN
      r_hcnt  <= w_hcnt_nxt;
`endif
    end
  end

  assign gnt  = r_gnt;
  assign busy = r_busy;
  assign q    = r_q;

endmodule
`default_nettype wire
